// File: rtl/mips_defs_pkg.sv
// Shared MIPS decode constants and fetch FSM state type for the fetch stage.
package mips_defs_pkg;

    // Primary opcode field IR[31:26]
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    // SPECIAL funct field IR[5:0]
    localparam logic [5:0] FUNCT_JR   = 6'b001000;
    localparam logic [5:0] FUNCT_JALR = 6'b001001;

    // REGIMM rt field IR[20:16]
    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;

    // Full encoding of eret
    localparam logic [31:0] ERET_INSN = 32'h4200_0018;

    // Fetch FSM: normal fetch, or the single cycle spent at the exception vector
    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } fetch_state_t;

    // Sign-extended word offset of a branch immediate, in bytes
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluation for beq/bne/blez/bgtz/bltz/bgez on signed operands.
module branch_cmp
    import mips_defs_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [4:0]  rt,
    input  logic [31:0] RS_D,
    input  logic [31:0] RT_D,
    output logic        cond
);

    logic signed [31:0] rs_s;
    logic signed [31:0] rt_s;

    assign rs_s = RS_D;
    assign rt_s = RT_D;

    // Condition is only ever true for a recognised conditional branch
    always_comb begin
        cond = 1'b0;
        unique case (op)
            OP_BEQ:    cond = (rs_s == rt_s);
            OP_BNE:    cond = (rs_s != rt_s);
            OP_BLEZ:   cond = (rs_s <= 32'sd0);
            OP_BGTZ:   cond = (rs_s >  32'sd0);
            OP_REGIMM: begin
                if (rt == RT_BLTZ)      cond = (rs_s <  32'sd0);
                else if (rt == RT_BGEZ) cond = (rs_s >= 32'sd0);
                else                    cond = 1'b0;
            end
            default:   cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_pc.sv
// Fetch-stage program counter with decode-stage redirect (delay slot kept).
// Optional misaligned-target trap enabled by defining FETCH_PC_ALIGN_CHK_EN.
module fetch_pc
    import mips_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [31:0]       IR_D,
    input  logic [ADDR_W-1:0] PC4_D,
    input  logic [31:0]       RS_D,
    input  logic [31:0]       RT_D,
    input  logic [ADDR_W-1:0] EPC_in,
    output logic [ADDR_W-1:0] PC_F,
    output logic [ADDR_W-1:0] PC4_F,
    output logic              taken_D,
    output logic              exc_req,
    output logic [ADDR_W-1:0] bad_addr
);

    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [4:0]        rt_field;
    logic              is_eret;
    logic              is_jump;
    logic              is_jreg;
    logic              br_cond;
    logic [31:0]       pc4_d_wide;
    logic [31:0]       jump_wide;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] next_pc;

    assign op       = IR_D[31:26];
    assign funct    = IR_D[5:0];
    assign rt_field = IR_D[20:16];

    assign is_eret  = (IR_D == ERET_INSN);
    assign is_jump  = (op == OP_J) || (op == OP_JAL);
    assign is_jreg  = (op == OP_SPECIAL) && ((funct == FUNCT_JR) || (funct == FUNCT_JALR));

    // Region bits come from the top nibble of a full 32-bit view of PC4_D so
    // the same expression works for every PC width.
    assign pc4_d_wide    = 32'(PC4_D);
    assign jump_wide     = (pc4_d_wide & 32'hF000_0000) | {4'b0000, IR_D[25:0], 2'b00};
    assign jump_target   = ADDR_W'(jump_wide);
    assign branch_target = PC4_D + ADDR_W'(branch_offset(IR_D[15:0]));

    assign PC4_F = PC_F + ADDR_W'(4);

    branch_cmp u_branch_cmp (
        .op   (op),
        .rt   (rt_field),
        .RS_D (RS_D),
        .RT_D (RT_D),
        .cond (br_cond)
    );

    // Next-PC selection: eret beats jumps, jumps beat branches, else fall through
    always_comb begin
        taken_D = 1'b1;
        next_pc = PC4_F;
        if (is_eret) begin
            next_pc = EPC_in;
        end else if (is_jump) begin
            next_pc = jump_target;
        end else if (is_jreg) begin
            next_pc = ADDR_W'(RS_D);
        end else if (br_cond) begin
            next_pc = branch_target;
        end else begin
            taken_D = 1'b0;
            next_pc = PC4_F;
        end
    end

`ifdef FETCH_PC_ALIGN_CHK_EN

    localparam logic [ADDR_W-1:0] EXC_ADDR = ADDR_W'(EXC_PC);

    fetch_state_t state;
    logic         misaligned;

    assign misaligned = taken_D && (next_pc[1:0] != 2'b00);

    // PC register and trap FSM; redirects are ignored for the cycle spent at the vector
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC_F     <= RESET_ADDR;
            state    <= RUN;
            exc_req  <= 1'b0;
            bad_addr <= '0;
        end else if (!stall) begin
            unique case (state)
                RUN: begin
                    if (misaligned) begin
                        state    <= TRAP;
                        PC_F     <= EXC_ADDR;
                        exc_req  <= 1'b1;
                        bad_addr <= next_pc;
                    end else begin
                        PC_F     <= next_pc;
                        exc_req  <= 1'b0;
                    end
                end
                TRAP: begin
                    state   <= RUN;
                    PC_F    <= PC4_F;
                    exc_req <= 1'b0;
                end
                default: begin
                    state   <= RUN;
                    PC_F    <= RESET_ADDR;
                    exc_req <= 1'b0;
                end
            endcase
        end
    end

`else

    logic unused_exc_pc;

    assign unused_exc_pc = ^EXC_PC;
    assign exc_req       = 1'b0;
    assign bad_addr      = '0;

    // PC register; misaligned targets are loaded exactly as computed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC_F <= RESET_ADDR;
        end else if (!stall) begin
            PC_F <= next_pc;
        end
    end

`endif

endmodule

// File: tb/tb_fetch_pc.sv
// Self-checking bench for fetch_pc: directed scenarios plus randomized run
// against a behavioural next-PC model. Honors FETCH_PC_ALIGN_CHK_EN.
module tb_fetch_pc;

    localparam int          AW       = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC   = 32'h0000_4180;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    logic          clk;
    logic          reset;
    logic          stall;
    logic [31:0]   IR_D;
    logic [AW-1:0] PC4_D;
    logic [31:0]   RS_D;
    logic [31:0]   RT_D;
    logic [AW-1:0] EPC_in;
    logic [AW-1:0] PC_F;
    logic [AW-1:0] PC4_F;
    logic          taken_D;
    logic          exc_req;
    logic [AW-1:0] bad_addr;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [31:0] m_pc;
    logic        m_trap;
    logic        m_exc;
    logic [31:0] m_bad;

    fetch_pc #(
        .RESET_PC (RESET_PC),
        .EXC_PC   (EXC_PC),
        .ADDR_W   (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .IR_D     (IR_D),
        .PC4_D    (PC4_D),
        .RS_D     (RS_D),
        .RT_D     (RT_D),
        .EPC_in   (EPC_in),
        .PC_F     (PC_F),
        .PC4_F    (PC4_F),
        .taken_D  (taken_D),
        .exc_req  (exc_req),
        .bad_addr (bad_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural decode of the instruction in D: is control transferred, and where
    function automatic void ref_decode(input logic [31:0] ir, input logic [31:0] pc4,
                                       input logic [31:0] rs, input logic [31:0] rt,
                                       input logic [31:0] epc,
                                       output logic take, output logic [31:0] tgt);
        int          s;
        int          t;
        int          imm;
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [4:0]  rtf;
        logic        cond;
        s    = rs;
        t    = rt;
        opc  = ir[31:26];
        fn   = ir[5:0];
        rtf  = ir[20:16];
        imm  = $signed(ir[15:0]);
        cond = 1'b0;
        case (opc)
            6'd4: cond = (s == t);
            6'd5: cond = (s != t);
            6'd6: cond = (s <= 0);
            6'd7: cond = (s > 0);
            6'd1: cond = (rtf == 5'd0) ? (s < 0) : ((rtf == 5'd1) ? (s >= 0) : 1'b0);
            default: cond = 1'b0;
        endcase
        take = 1'b1;
        if (ir == 32'h4200_0018)                       tgt = epc;
        else if (opc == 6'd2 || opc == 6'd3)           tgt = {pc4[31:28], ir[25:0], 2'b00};
        else if (opc == 6'd0 && (fn == 6'd8 || fn == 6'd9)) tgt = rs;
        else if (cond)                                 tgt = pc4 + 32'(imm * 4);
        else begin
            take = 1'b0;
            tgt  = 32'h0;
        end
    endfunction

    function automatic logic model_take();
        logic        tk;
        logic [31:0] tg;
        ref_decode(IR_D, PC4_D, RS_D, RT_D, EPC_in, tk, tg);
        return tk;
    endfunction

    task automatic model_reset();
        m_pc   = RESET_PC;
        m_trap = 1'b0;
        m_exc  = 1'b0;
        m_bad  = 32'h0;
    endtask

    // Advance the model by one clock using the inputs currently driven, then clock the DUT
    task automatic tick();
        logic        tk;
        logic [31:0] tg;
        ref_decode(IR_D, PC4_D, RS_D, RT_D, EPC_in, tk, tg);
        if (!stall) begin
            if (m_trap) begin
                m_trap = 1'b0;
                m_exc  = 1'b0;
                m_pc   = m_pc + 32'd4;
            end else begin
                m_exc = 1'b0;
                if (!tk) m_pc = m_pc + 32'd4;
`ifdef FETCH_PC_ALIGN_CHK_EN
                else if (tg[1:0] != 2'b00) begin
                    m_trap = 1'b1;
                    m_exc  = 1'b1;
                    m_bad  = tg;
                    m_pc   = EXC_PC;
                end
`endif
                else m_pc = tg;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ir, input logic [31:0] pc4, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] epc, input logic st);
        IR_D   = ir;
        PC4_D  = pc4;
        RS_D   = rs;
        RT_D   = rt;
        EPC_in = epc;
        stall  = st;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(NOP, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        checks++; if (PC_F !== 32'h0000_3000) begin errors++; $display("[TB] FAIL reset_pc got %h want %h", PC_F, 32'h0000_3000); end
        checks++; if (exc_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_exc got %b want 0", exc_req); end
        checks++; if (bad_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_bad got %h want 0", bad_addr); end
        reset = 1'b0;
        tick();
        checks++; if (PC_F !== 32'h0000_3004) begin errors++; $display("[TB] FAIL release_pc1 got %h want %h", PC_F, 32'h0000_3004); end
        tick();
        checks++; if (PC_F !== 32'h0000_3008) begin errors++; $display("[TB] FAIL release_pc2 got %h want %h", PC_F, 32'h0000_3008); end
        checks++; if (PC4_F !== 32'h0000_300C) begin errors++; $display("[TB] FAIL release_pc4 got %h want %h", PC4_F, 32'h0000_300C); end
    endtask

    task automatic test_beq();
        drive({6'b000100, 5'd1, 5'd2, 16'hFFFE}, 32'h0000_3008, 32'd5, 32'd5, 32'h0, 1'b0);
        #1;
        checks++; if (taken_D !== 1'b1) begin errors++; $display("[TB] FAIL beq_taken got %b want 1", taken_D); end
        tick();
        checks++; if (PC_F !== 32'h0000_3000) begin errors++; $display("[TB] FAIL beq_target got %h want %h", PC_F, 32'h0000_3000); end
        RT_D = 32'd6;
        #1;
        checks++; if (taken_D !== 1'b0) begin errors++; $display("[TB] FAIL beq_untaken got %b want 0", taken_D); end
        tick();
        checks++; if (PC_F !== 32'h0000_3004) begin errors++; $display("[TB] FAIL beq_fallthru got %h want %h", PC_F, 32'h0000_3004); end
    endtask

    task automatic test_regimm();
        drive({6'b000001, 5'd3, 5'd0, 16'h0004}, 32'h0000_3008, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
        #1;
        checks++; if (taken_D !== 1'b1) begin errors++; $display("[TB] FAIL bltz_taken got %b want 1", taken_D); end
        tick();
        checks++; if (PC_F !== 32'h0000_3018) begin errors++; $display("[TB] FAIL bltz_target got %h want %h", PC_F, 32'h0000_3018); end
        IR_D = {6'b000001, 5'd3, 5'd1, 16'h0004};
        #1;
        checks++; if (taken_D !== 1'b0) begin errors++; $display("[TB] FAIL bgez_taken got %b want 0", taken_D); end
        tick();
        checks++; if (PC_F !== 32'h0000_301C) begin errors++; $display("[TB] FAIL bgez_pc got %h want %h", PC_F, 32'h0000_301C); end
    endtask

    task automatic test_eret();
        drive(32'h4200_0018, 32'h0000_3020, 32'h0, 32'h0, 32'h0000_3010, 1'b0);
        #1;
        checks++; if (taken_D !== 1'b1) begin errors++; $display("[TB] FAIL eret_taken got %b want 1", taken_D); end
        tick();
        checks++; if (PC_F !== 32'h0000_3010) begin errors++; $display("[TB] FAIL eret_pc got %h want %h", PC_F, 32'h0000_3010); end
    endtask

    task automatic test_stall();
        drive({6'b000011, 26'h000_0C40}, 32'h0000_3014, 32'h0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (PC_F !== 32'h0000_3010) begin errors++; $display("[TB] FAIL stall_hold%0d got %h want %h", i, PC_F, 32'h0000_3010); end
        end
        stall = 1'b0;
        tick();
        checks++; if (PC_F !== 32'h0000_3100) begin errors++; $display("[TB] FAIL stall_release got %h want %h", PC_F, 32'h0000_3100); end
    endtask

    task automatic test_misaligned();
        drive({6'b000000, 5'd4, 15'd0, 6'b001000}, 32'h0000_3104, 32'h0000_3002, 32'h0, 32'h0, 1'b0);
        tick();
`ifdef FETCH_PC_ALIGN_CHK_EN
        checks++; if (PC_F !== 32'h0000_4180) begin errors++; $display("[TB] FAIL trap_pc got %h want %h", PC_F, 32'h0000_4180); end
        checks++; if (exc_req !== 1'b1) begin errors++; $display("[TB] FAIL trap_exc got %b want 1", exc_req); end
        checks++; if (bad_addr !== 32'h0000_3002) begin errors++; $display("[TB] FAIL trap_bad got %h want %h", bad_addr, 32'h0000_3002); end
        tick();
        checks++; if (PC_F !== 32'h0000_4184) begin errors++; $display("[TB] FAIL trap_next got %h want %h", PC_F, 32'h0000_4184); end
        checks++; if (exc_req !== 1'b0) begin errors++; $display("[TB] FAIL trap_pulse got %b want 0", exc_req); end
`else
        checks++; if (PC_F !== 32'h0000_3002) begin errors++; $display("[TB] FAIL misaligned_pc got %h want %h", PC_F, 32'h0000_3002); end
        checks++; if (exc_req !== 1'b0) begin errors++; $display("[TB] FAIL misaligned_exc got %b want 0", exc_req); end
        tick();
        checks++; if (PC_F !== m_pc[AW-1:0]) begin errors++; $display("[TB] FAIL misaligned_next got %h want %h", PC_F, m_pc); end
`endif
    endtask

    task automatic test_wrap();
        drive({6'b000000, 5'd4, 15'd0, 6'b001001}, 32'h0000_4188, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        tick();
        checks++; if (PC_F !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_load got %h want %h", PC_F, 32'hFFFF_FFFC); end
        checks++; if (PC4_F !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc4 got %h want 0", PC4_F); end
        IR_D = NOP;
        tick();
        checks++; if (PC_F !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc got %h want 0", PC_F); end
    endtask

    task automatic test_reset_mid_trap();
        drive({6'b000000, 5'd4, 15'd0, 6'b001000}, 32'h0000_0004, 32'h0000_5001, 32'h0, 32'h0, 1'b0);
        tick();
        stall = 1'b1;
        tick();
        reset = 1'b1;
        #1;
        model_reset();
        checks++; if (PC_F !== 32'h0000_3000) begin errors++; $display("[TB] FAIL midtrap_reset_pc got %h want %h", PC_F, 32'h0000_3000); end
        checks++; if (exc_req !== 1'b0) begin errors++; $display("[TB] FAIL midtrap_reset_exc got %b want 0", exc_req); end
        checks++; if (bad_addr !== 32'h0) begin errors++; $display("[TB] FAIL midtrap_reset_bad got %h want 0", bad_addr); end
        @(posedge clk); #1;
        reset = 1'b0;
        drive(NOP, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        checks++; if (PC_F !== 32'h0000_3004) begin errors++; $display("[TB] FAIL midtrap_release got %h want %h", PC_F, 32'h0000_3004); end
        checks++; if (exc_req !== 1'b0) begin errors++; $display("[TB] FAIL midtrap_release_exc got %b want 0", exc_req); end
    endtask

    task automatic test_random();
        logic [31:0] ir;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] epc;
        logic [31:0] pc4;
        logic        exp_take;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0: ir = {6'b000010, 26'($urandom)};
                1: ir = {6'b000011, 26'($urandom)};
                2: ir = {6'b000100, 10'($urandom), 16'($urandom)};
                3: ir = {6'b000101, 10'($urandom), 16'($urandom)};
                4: ir = {6'b000110, 10'($urandom), 16'($urandom)};
                5: ir = {6'b000111, 10'($urandom), 16'($urandom)};
                6: ir = {6'b000001, 5'($urandom), 5'($urandom_range(0, 2)), 16'($urandom)};
                7: ir = {6'b000000, 20'($urandom), ($urandom_range(0, 1) == 1) ? 6'b001001 : 6'b001000};
                8: ir = 32'h4200_0018;
                default: ir = $urandom;
            endcase
            rs = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) != 0) rs[1:0] = 2'b00;
            rt  = ($urandom_range(0, 1) == 1) ? rs : $urandom;
            pc4 = $urandom;
            pc4[1:0] = 2'b00;
            epc = $urandom;
            if ($urandom_range(0, 3) != 0) epc[1:0] = 2'b00;
            drive(ir, pc4, rs, rt, epc, ($urandom_range(0, 4) == 0));
            #1;
            exp_take = model_take();
            checks++; if (taken_D !== exp_take) begin errors++; $display("[TB] FAIL rnd_taken[%0d] ir %h got %b want %b", n, ir, taken_D, exp_take); end
            tick();
            checks++; if (PC_F !== m_pc[AW-1:0]) begin errors++; $display("[TB] FAIL rnd_pc[%0d] got %h want %h", n, PC_F, m_pc); end
            checks++; if (PC4_F !== m_pc[AW-1:0] + 32'd4) begin errors++; $display("[TB] FAIL rnd_pc4[%0d] got %h want %h", n, PC4_F, m_pc + 32'd4); end
            checks++; if (exc_req !== m_exc) begin errors++; $display("[TB] FAIL rnd_exc[%0d] got %b want %b", n, exc_req, m_exc); end
            checks++; if (bad_addr !== m_bad[AW-1:0]) begin errors++; $display("[TB] FAIL rnd_bad[%0d] got %h want %h", n, bad_addr, m_bad); end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(NOP, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        model_reset();
        test_reset();
        test_beq();
        test_regimm();
        test_eret();
        test_stall();
        test_misaligned();
        test_wrap();
        test_reset_mid_trap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc.md
FETCH_PC -- requirements
Module: fetch_pc

Interface
- REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning fetch address loaded on reset.
- REQ-002 SHALL have parameter EXC_PC, default 32'h0000_4180, meaning exception entry vector.
- REQ-003 SHALL have parameter ADDR_W, default 32, meaning PC width (legal range 16..32; upper bits above ADDR_W ignored).
- REQ-004 SHALL have port clk  input  1  system clock, single clock domain, rising edge.
- REQ-005 SHALL have port reset  input  1  asynchronous active-high reset.
- REQ-006 SHALL have port stall  input  1  hold PC_F (hazard unit).
- REQ-007 SHALL have port IR_D  input  32  instruction in decode stage.
- REQ-008 SHALL have port PC4_D  input  ADDR_W  decode-stage PC+4.
- REQ-009 SHALL have port RS_D  input  32  forwarded rs value.
- REQ-010 SHALL have port RT_D  input  32  forwarded rt value.
- REQ-011 SHALL have port EPC_in  input  ADDR_W  return address for eret.
- REQ-012 SHALL have port PC_F  output  ADDR_W  current fetch address (registered).
- REQ-013 SHALL have port PC4_F  output  ADDR_W  PC_F+4.
- REQ-014 SHALL have port taken_D  output  1  decode-stage control transfer selected (combinational).
- REQ-015 SHALL have port exc_req  output  1  registered misalignment trap pulse (macro only, else tied 0).
- REQ-016 SHALL have port bad_addr  output  ADDR_W  registered faulting target (macro only, else 0).

Function
- REQ-017 SHALL decode: j(000010), jal(000011), beq(000100), bne(000101), blez(000110), bgtz(000111), regimm(000001: rt=00000 bltz, rt=00001 bgez), special(000000: funct 001000 jr, 001001 jalr), eret (IR_D==32'h4200_0018).
- REQ-018 SHALL compute branch target = PC4_D + (sign-extended IR_D[15:0] << 2), truncated to ADDR_W.
- REQ-019 SHALL compute jump target = {PC4_D[ADDR_W-1:28], IR_D[25:0], 2'b00}; jr/jalr target = RS_D[ADDR_W-1:0].
- REQ-020 SHALL evaluate branch conditions on signed 32-bit RS_D/RT_D; untaken branch and any other instruction select PC_F+4.
- REQ-021 SHALL use priority eret > jump/jr/jalr > taken branch > PC_F+4 for next PC.
- REQ-022 SHALL keep architectural delay slot: redirect takes effect one cycle after the transfer is in D; no flush output.
- REQ-023 SHALL, when stall=1, hold PC_F, exc_req, bad_addr and FSM state unchanged regardless of IR_D.
- REQ-024 SHALL implement FSM states RUN and TRAP; RUN->TRAP on misaligned selected target (target[1:0]!=0) with stall=0; TRAP->RUN unconditionally next non-stalled cycle.
- REQ-025 SHALL, on entering TRAP, load PC_F=EXC_PC, set exc_req=1 for exactly one non-stalled cycle, latch bad_addr=faulting target.
- REQ-026 SHALL ignore IR_D redirects while in TRAP (PC_F advances by 4 from EXC_PC).
- REQ-027 SHALL wrap PC arithmetic modulo 2^ADDR_W (PC_F=max-3 -> next PC 0).

Reset
- REQ-028 SHALL on reset asynchronously set PC_F=RESET_PC, state=RUN, exc_req=0, bad_addr=0.
- REQ-029 SHALL, if reset asserts mid-TRAP or mid-stall, abandon it; first fetch after release is RESET_PC.

Configuration
- REQ-030 SHALL use macro FETCH_PC_ALIGN_CHK_EN: defined -> REQ-024..026 active; undefined -> FSM absent, misaligned targets loaded as-is, exc_req=0, bad_addr=0.

Structure
- REQ-031 SHALL place opcode/funct constants, ERET encoding and FSM state typedef in shared package mips_defs_pkg.
- REQ-032 SHALL isolate branch-condition evaluation in sub-module branch_cmp (inputs op, rt field, RS_D, RT_D; output cond).

Verification
- REQ-033 SHALL check reset: assert reset -> PC_F=32'h0000_3000, exc_req=0; release -> 3004, 3008.
- REQ-034 SHALL check beq taken: PC4_D=3008, imm=16'hFFFE, RS=RT=5 -> taken_D=1, next PC_F=3000; RS!=RT -> PC_F+4.
- REQ-035 SHALL check bltz/bgez with RS_D=32'hFFFF_FFFF: bltz taken, bgez not taken.
- REQ-036 SHALL check stall: stall=1 for 3 cycles with jal in D -> PC_F constant; release -> jump target loaded.
- REQ-037 SHALL check jr RS_D=32'h0000_3002 (macro on) -> PC_F=4180, exc_req=1 one cycle, bad_addr=3002; macro off -> PC_F=3002.
- REQ-038 SHALL check eret with simultaneous j: EPC_in=3010 wins; PC_F=3010.
